frame_grant_controller: RTL and testbench
=========================================

Name: frame_grant_controller

Overview:
- Sequential grant stage directly downstream of the combinational priority encoder in the MAC transmit path.
- Drives the encoder's enable, latches its one-hot result as a registered grant, and holds it for a whole frame.
- Releases the grant on end-of-frame, requester abort, or (optionally) watchdog timeout, then re-arbitrates.
- Output grant feeds the transmit data mux and the per-client acknowledge logic.

Parameters:
- NO_INPUTS, 4, number of requesting clients (width of req/enc_out/grant).
- INDEX_WIDTH, 2, width of grant_index; must equal clog2(NO_INPUTS), minimum 1.
- TIMEOUT_CYCLES, 1024, maximum consecutive GRANT cycles before forced release (used only with macro).
- TIMEOUT_WIDTH, 11, counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NO_INPUTS  per-client frame request, level, held until grant+frame_done.
- enc_enable  output  1  enable to priority encoder.
- enc_out  input  NO_INPUTS  one-hot result from priority encoder (combinational from req).
- frame_done  input  1  single-cycle end-of-frame strobe from the granted client's path.
- grant  output  NO_INPUTS  registered one-hot grant, zero when idle.
- grant_valid  output  1  high while a grant is held.
- grant_index  output  INDEX_WIDTH  binary index of the set grant bit, 0 when idle.
- timeout  output  1  single-cycle pulse on watchdog release (tied 0 without macro).

Behaviour:
- Clock and reset: single clock domain (clk); reset is synchronous and active-high.
- Reset: state IDLE; grant=0, grant_valid=0, grant_index=0, timeout=0, enc_enable=0, counter=0. Reset mid-frame drops the grant at that edge, with no RELEASE cycle.
- enc_enable is a decode of state: 1 only in SELECT.
- IDLE:
  - If |req, go to SELECT next cycle.
  - frame_done is ignored.
- SELECT:
  - Let sel = enc_out & req.
  - If sel == 0 (request withdrawn), return to IDLE.
  - Else grant <= lowest set bit of sel (a multi-hot enc_out is a protocol violation and is resolved to the lowest bit), grant_index <= its position, grant_valid <= 1, go to GRANT.
- GRANT:
  - Hold grant and grant_index stable.
  - frame_done=1 goes to RELEASE.
  - req bit of the granted client deasserting (abort) goes to RELEASE.
  - Both in the same cycle give a single RELEASE.
- RELEASE:
  - grant, grant_valid and grant_index are cleared at entry (the registered outputs are 0 during RELEASE).
  - Unconditionally go to IDLE next cycle.
- Latency:
  - req rising in IDLE at edge N gives SELECT at N+1 and grant_valid=1 at N+2.
  - frame_done sampled at edge M gives grant_valid=0 from M+1.
  - The earliest next grant_valid is M+4 (RELEASE, IDLE, SELECT).
- Priority: fixed, lowest index wins, inherited from the encoder. There is no fairness mask.
- grant is always zero or exactly one-hot. grant_valid == |grant at all times.

Optional Feature:
- Macro: FRAME_GRANT_CONTROLLER_TIMEOUT_EN.
- Defined:
  - TIMEOUT_WIDTH-bit counter clears on GRANT entry and increments each GRANT cycle without frame_done.
  - When the counter reaches TIMEOUT_CYCLES-1 in GRANT, the state goes to RELEASE and timeout pulses 1 for exactly the RELEASE cycle.
  - frame_done on the same cycle takes precedence, with no timeout pulse.
- Undefined: no counter is built, timeout is tied 0, and a grant is held indefinitely.

Test Plan:
- reset, then req=4'b0110 at edge 1 -> enc_enable=1 at cycle 2; grant=4'b0010, grant_index=1, grant_valid=1 from edge 3.
- Grant held on client 1, req changes to 4'b0111 -> grant remains 4'b0010 until frame_done; after RELEASE/IDLE/SELECT, grant=4'b0001.
- req=4'b1000 to SELECT, req drops to 0 during SELECT -> return to IDLE, grant stays 0, grant_valid never rises.
- Granted client 2 deasserts req[2] and frame_done pulses in the same cycle -> a single RELEASE cycle, grant=0, then IDLE.
- enc_out forced to 4'b1010 with req=4'b1111 in SELECT -> grant=4'b0010 (lowest bit).
- Macro defined, TIMEOUT_CYCLES=8, grant held with no frame_done -> timeout=1 for one cycle, grant=0 after 8 GRANT cycles; macro undefined -> grant still held at 100 cycles, timeout=0.
- Reset asserted in GRANT -> next edge grant=0, grant_valid=0, grant_index=0, state IDLE.

Source files
------------

// File: rtl/frame_grant_controller_if.sv
// Handshake bundle between the frame grant controller and its clients/priority encoder.
// The master modport is the controller; the slave modport is the requesting side.
interface frame_grant_controller_if #(
    parameter int NO_INPUTS   = 4,
    parameter int INDEX_WIDTH = 2
);
    logic [NO_INPUTS-1:0]   req;
    logic                   enc_enable;
    logic [NO_INPUTS-1:0]   enc_out;
    logic                   frame_done;
    logic [NO_INPUTS-1:0]   grant;
    logic                   grant_valid;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic                   timeout;

    modport master (
        input  req, enc_out, frame_done,
        output enc_enable, grant, grant_valid, grant_index, timeout
    );

    modport slave (
        output req, enc_out, frame_done,
        input  enc_enable, grant, grant_valid, grant_index, timeout
    );
endinterface

// File: rtl/frame_grant_controller.sv
// Registered frame grant stage behind the transmit priority encoder.
// Optional watchdog release is built when FRAME_GRANT_CONTROLLER_TIMEOUT_EN is defined.
module frame_grant_controller #(
    parameter int NO_INPUTS      = 4,
    parameter int INDEX_WIDTH    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_WIDTH  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    frame_grant_controller_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                 state;
    logic [NO_INPUTS-1:0]   grant_r;
    logic [INDEX_WIDTH-1:0] grant_index_r;
    logic                   grant_valid_r;
    logic                   enc_enable_r;
    logic                   timeout_r;

    logic [NO_INPUTS-1:0]   sel;
    logic [NO_INPUTS-1:0]   sel_low;
    logic [INDEX_WIDTH-1:0] sel_idx;
    logic                   abort;

    // Multi-hot encoder output is a protocol violation; the lowest bit wins.
    function automatic logic [NO_INPUTS-1:0] lowest_bit(input logic [NO_INPUTS-1:0] v);
        logic [NO_INPUTS-1:0] r;
        r = '0;
        for (int i = NO_INPUTS - 1; i >= 0; i--) begin
            if (v[i]) r = '0;
            if (v[i]) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] lowest_index(input logic [NO_INPUTS-1:0] v);
        logic [INDEX_WIDTH-1:0] r;
        r = '0;
        for (int i = NO_INPUTS - 1; i >= 0; i--) begin
            if (v[i]) r = INDEX_WIDTH'(i);
        end
        return r;
    endfunction

    always_comb begin
        sel     = bus.enc_out & bus.req;
        sel_low = lowest_bit(sel);
        sel_idx = lowest_index(sel);
        abort   = ~|(bus.req & grant_r);
    end

`ifdef FRAME_GRANT_CONTROLLER_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] counter;
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
`else
    logic [TIMEOUT_WIDTH-1:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            grant_r       <= '0;
            grant_index_r <= '0;
            grant_valid_r <= 1'b0;
            enc_enable_r  <= 1'b0;
            timeout_r     <= 1'b0;
`ifdef FRAME_GRANT_CONTROLLER_TIMEOUT_EN
            counter       <= '0;
`endif
        end else begin
            timeout_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state        <= SELECT;
                        enc_enable_r <= 1'b1;
                    end
                end
                SELECT: begin
                    enc_enable_r <= 1'b0;
                    if (sel == '0) begin
                        state <= IDLE;
                    end else begin
                        state         <= GRANT;
                        grant_r       <= sel_low;
                        grant_index_r <= sel_idx;
                        grant_valid_r <= 1'b1;
`ifdef FRAME_GRANT_CONTROLLER_TIMEOUT_EN
                        counter       <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (bus.frame_done || abort) begin
                        state         <= RELEASE;
                        grant_r       <= '0;
                        grant_index_r <= '0;
                        grant_valid_r <= 1'b0;
`ifdef FRAME_GRANT_CONTROLLER_TIMEOUT_EN
                    end else if (counter == TIMEOUT_LAST) begin
                        state         <= RELEASE;
                        grant_r       <= '0;
                        grant_index_r <= '0;
                        grant_valid_r <= 1'b0;
                        timeout_r     <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_index = grant_index_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.enc_enable  = enc_enable_r;
    assign bus.timeout     = timeout_r;

endmodule

// File: tb/tb_frame_grant_controller.sv
// Directed bench for frame_grant_controller with a lowest-index priority encoder model.
// Watchdog checks follow FRAME_GRANT_CONTROLLER_TIMEOUT_EN.
module tb_frame_grant_controller;

`ifdef FRAME_GRANT_CONTROLLER_TIMEOUT_EN
    localparam int TO_CYCLES = 8;
`else
    localparam int TO_CYCLES = 1024;
`endif

    logic clk;
    logic reset;
    logic enc_force_en;
    logic [3:0] enc_force;
    int total;
    int bad;

    frame_grant_controller_if #(.NO_INPUTS(4), .INDEX_WIDTH(2)) bus ();

    frame_grant_controller #(
        .NO_INPUTS(4),
        .INDEX_WIDTH(2),
        .TIMEOUT_CYCLES(TO_CYCLES),
        .TIMEOUT_WIDTH(11)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Encoder model: isolate lowest set request bit unless a test overrides it.
    assign bus.enc_out = enc_force_en ? enc_force : (bus.req & (~bus.req + 4'd1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                           input logic v, input logic en);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".index"}, 32'(bus.grant_index), 32'(idx));
        chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(v));
        chk({tag, ".enc_en"}, 32'(bus.enc_enable), 32'(en));
    endtask

    initial begin
        int held_bad;
        int to_seen;
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.req = 4'b0000;
        bus.frame_done = 1'b0;
        enc_force_en = 1'b0;
        enc_force = 4'b0000;
        tick();
        tick();
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("reset.timeout", 32'(bus.timeout), 32'd0);
        reset = 1'b0;

        // Basic grant: client 1 wins over client 2
        bus.req = 4'b0110;
        tick();
        chk_out("t1.select", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_out("t1.grant", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Higher-priority request while granted does not preempt
        bus.req = 4'b0111;
        tick();
        tick();
        tick();
        chk_out("t2.hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        chk_out("t2.release", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_out("t2.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_out("t2.select", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_out("t2.regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        chk_out("t2.abort", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();

        // Request withdrawn during SELECT
        bus.req = 4'b1000;
        tick();
        chk_out("t3.select", 4'b0000, 2'd0, 1'b0, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk_out("t3.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_out("t3.idle2", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Abort and frame_done together
        bus.req = 4'b0100;
        tick();
        tick();
        chk_out("t4.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus.req = 4'b0000;
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        chk_out("t4.release", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("t4.timeout", 32'(bus.timeout), 32'd0);
        tick();
        chk_out("t4.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_out("t4.idle2", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Multi-hot encoder output resolved to lowest bit
        enc_force_en = 1'b1;
        enc_force = 4'b1010;
        bus.req = 4'b1111;
        tick();
        chk_out("t5.select", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_out("t5.grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        enc_force_en = 1'b0;

        // Watchdog behaviour on a held grant
        held_bad = 0;
        to_seen = 0;
`ifdef FRAME_GRANT_CONTROLLER_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.grant !== 4'b0010 || bus.timeout !== 1'b0) held_bad++;
        end
        chk("t6.held7", 32'(held_bad), 32'd0);
        tick();
        chk("t6.timeout", 32'(bus.timeout), 32'd1);
        chk_out("t6.forced", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk("t6.pulse_end", 32'(bus.timeout), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.grant !== 4'b0010) held_bad++;
            if (bus.timeout !== 1'b0) to_seen++;
        end
        chk("t6.held100", 32'(held_bad), 32'd0);
        chk("t6.no_timeout", 32'(to_seen), 32'd0);
        chk_out("t6.still", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        chk_out("t6.release", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif
        bus.req = 4'b0000;
        tick();
        tick();

        // Reset while granted
        bus.req = 4'b1000;
        tick();
        tick();
        chk_out("t7.grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk_out("t7.reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        bus.req = 4'b0000;
        tick();
        chk_out("t7.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
